instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Fetch/decode/execute control sequencer for the SAP-2 datapath; it is the consumer of the ALU's flags and the driver of its operation select and flag-latch strobe. A T-state counter steps each instruction through fetch and execute. Per-state combinational decode drives one-cycle control strobes to the PC, MAR, RAM, IR, A, T and ALU. Downstream registers qualify every strobe with `clk_en`.

## Interface
- `ALU_OP_WIDTH`, 4, width of the ALU operation select.
- `ALU_SUB_CODE`, 4'd1, ALU op code driven for CMP (subtract).
- `clk` in 1: system clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: state advances only on edges where high.
- `i_instruction` in 8: IR contents; valid from T2 onward. [7:4] class, [3:0] sub-code.
- `i_zero`, `i_carry`, `i_odd` in 1 each: latched ALU flags.
- `o_pc_out`, `o_pc_inc`, `o_pc_load` out 1 each: PC drive bus / increment / load from bus.
- `o_mar_load`, `o_ram_out`, `o_ram_write`, `o_ir_load` out 1 each.
- `o_a_load`, `o_a_out`, `o_t_load`, `o_alu_out` out 1 each.
- `o_latch_flags` out 1: ALU flag latch request.
- `o_alu_op` out ALU_OP_WIDTH: ALU operation select.
- `o_halt` out 1: high while halted.
- `o_tstate` out 3: current T-state, for debug.

## Operation
- States: T0–T4 (encoded 0–4) and HALT (encoded 7). Register reset to T0.
- All strobes are combinational from the state register and `i_instruction`. Any strobe not listed for a state is 0. `o_alu_op` = `i_instruction[3:0]` in every state except CMP-T2, where it is `ALU_SUB_CODE`.
- Fetch, all instructions:
  - T0: `pc_out`, `mar_load`.
  - T1: `ram_out`, `ir_load`, `pc_inc`.
  - T2 onward: execute, decoded by class.
- Class 0x0 NOP: T2, no strobes, then T0.
- Class 0x1 LDA addr:
  - T2: `pc_out`, `mar_load`.
  - T3: `ram_out`, `mar_load`, `pc_inc`.
  - T4: `ram_out`, `a_load`, then T0.
- Class 0x2 STA addr: T2 and T3 as LDA; T4: `a_out`, `ram_write`, then T0.
- Class 0x3 LDT imm:
  - T2: `pc_out`, `mar_load`.
  - T3: `ram_out`, `t_load`, `pc_inc`, then T0.
- Class 0x4 ALU: T2: `alu_out`, `a_load`, `latch_flags`, then T0.
- Class 0x5 CMP: T2: `latch_flags` only, then T0. A is not written.
- Class 0x6 JMP / class 0x7 Jcc addr:
  - T2: `pc_out`, `mar_load`.
  - T3: `ram_out` plus `pc_load` if taken, else `pc_inc`; then T0.
- Jcc condition:
  - `sub[1:0]`: 00 zero, 01 carry, 10 odd, 11 always.
  - `sub[2]`=1 inverts the condition.
  - JMP is always taken.
- Class 0xF HLT: T2 → HALT. In HALT all strobes are 0 and `o_halt`=1. Exit only by reset.
- Classes 0x8–0xE are treated as NOP.

## Timing
- Reset (`rst_n` low, any time, including mid-instruction): state=T0 immediately.
  - Outputs during reset: `o_pc_out`=1, `o_mar_load`=1, `o_tstate`=0, `o_alu_op`=`i_instruction[3:0]`, all other outputs 0.
  - First transition occurs on the first `clk_en` edge after release.
- Transitions occur only on rising `clk` with `clk_en`=1. With `clk_en`=0 the state and all strobes hold unchanged.
- Cycle counts per instruction, in enabled cycles: NOP/ALU/CMP 3, LDT/JMP/Jcc 4, LDA/STA 5.
- Flags are sampled combinationally in T3. They reflect the last `latch_flags` edge, so CMP followed immediately by Jcc sees the new flags.
- The decoder never asserts two bus drivers (`pc_out`, `ram_out`, `a_out`, `alu_out`) in the same state.

## Test plan
- Reset sequencing:
  - Stimulus: hold `rst_n`=0, toggle `clk`.
  - Required: `o_tstate`=0, `o_pc_out`=`o_mar_load`=1, all other strobes 0.
  - After release with `clk_en`=1, `o_tstate` steps 0→1→2.
- LDA (0x10):
  - Required strobe sequence T0 {pc_out,mar_load}, T1 {ram_out,ir_load,pc_inc}, T2 {pc_out,mar_load}, T3 {ram_out,mar_load,pc_inc}, T4 {ram_out,a_load}.
  - `o_tstate` returns to 0 after 5 enabled cycles.
- ALU and CMP:
  - 0x42 at T2: `alu_out`=`a_load`=`latch_flags`=1, `o_alu_op`=2.
  - 0x57 at T2: `latch_flags`=1, `a_load`=0, `o_alu_op`=1.
- Jcc:
  - 0x70 with `i_zero`=1: T3 `pc_load`=1, `pc_inc`=0.
  - 0x70 with `i_zero`=0: `pc_inc`=1.
  - 0x74 with `i_zero`=0: `pc_load`=1.
  - 0x73: always taken.
- `clk_en` gating:
  - Stimulus: drop `clk_en` for 5 cycles at T3 of an LDA.
  - Required: state and strobes frozen; resumes to T4 on re-enable.
- HLT and mid-instruction reset:
  - 0xF0: HALT reached, `o_halt`=1, no strobes for 20 cycles.
  - Asserting `rst_n`=0 in HALT, or in T3 of a JMP, returns to T0 with reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: SAP-2 fetch/decode/execute control sequencer.
// A T-state register steps each instruction through fetch (T0-T1) and
// execute (T2-T4); control strobes are decoded combinationally from the
// current state and the instruction register contents.
module instruction_sequencer #(
   parameter int unsigned               ALU_OP_WIDTH = 4,
   parameter logic [ALU_OP_WIDTH-1:0]   ALU_SUB_CODE = 4'd1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   input  logic [7:0]              i_instruction,
   input  logic                    i_zero,
   input  logic                    i_carry,
   input  logic                    i_odd,
   output logic                    o_pc_out,
   output logic                    o_pc_inc,
   output logic                    o_pc_load,
   output logic                    o_mar_load,
   output logic                    o_ram_out,
   output logic                    o_ram_write,
   output logic                    o_ir_load,
   output logic                    o_a_load,
   output logic                    o_a_out,
   output logic                    o_t_load,
   output logic                    o_alu_out,
   output logic                    o_latch_flags,
   output logic [ALU_OP_WIDTH-1:0] o_alu_op,
   output logic                    o_halt,
   output logic [2:0]              o_tstate
);

   typedef enum logic [2:0] {
      T0   = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      HALT = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP = 4'h0,
      CLS_LDA = 4'h1,
      CLS_STA = 4'h2,
      CLS_LDT = 4'h3,
      CLS_ALU = 4'h4,
      CLS_CMP = 4'h5,
      CLS_JMP = 4'h6,
      CLS_JCC = 4'h7,
      CLS_HLT = 4'hF
   } op_class_t;

   state_t     state;
   logic [3:0] op_class;
   logic [3:0] sub;
   logic       cond_flag;
   logic       jump_taken;

   assign op_class = i_instruction[7:4];
   assign sub      = i_instruction[3:0];
   assign o_tstate = state;

   // Jump condition: select flag by sub[1:0], invert with sub[2]; JMP always taken
   always_comb begin
      cond_flag = 1'b1;
      case (sub[1:0])
         2'b00:   cond_flag = i_zero;
         2'b01:   cond_flag = i_carry;
         2'b10:   cond_flag = i_odd;
         default: cond_flag = 1'b1;
      endcase
      jump_taken = (op_class == CLS_JMP) ? 1'b1 : (cond_flag ^ sub[2]);
   end

   // T-state register: advances only on enabled edges, HALT exits only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= T0;
      end else if (clk_en) begin
         case (state)
            T0: state <= T1;
            T1: state <= T2;
            T2: begin
               case (op_class)
                  CLS_LDA, CLS_STA, CLS_LDT, CLS_JMP, CLS_JCC: state <= T3;
                  CLS_HLT: state <= HALT;
                  default: state <= T0;
               endcase
            end
            T3: begin
               case (op_class)
                  CLS_LDA, CLS_STA: state <= T4;
                  default:          state <= T0;
               endcase
            end
            T4:      state <= T0;
            HALT:    state <= HALT;
            default: state <= T0;
         endcase
      end
   end

   // Per-state control decode; every strobe defaults low
   always_comb begin
      o_pc_out      = 1'b0;
      o_pc_inc      = 1'b0;
      o_pc_load     = 1'b0;
      o_mar_load    = 1'b0;
      o_ram_out     = 1'b0;
      o_ram_write   = 1'b0;
      o_ir_load     = 1'b0;
      o_a_load      = 1'b0;
      o_a_out       = 1'b0;
      o_t_load      = 1'b0;
      o_alu_out     = 1'b0;
      o_latch_flags = 1'b0;
      o_halt        = 1'b0;
      o_alu_op      = ALU_OP_WIDTH'(sub);
      case (state)
         T0: begin
            o_pc_out   = 1'b1;
            o_mar_load = 1'b1;
         end
         T1: begin
            o_ram_out = 1'b1;
            o_ir_load = 1'b1;
            o_pc_inc  = 1'b1;
         end
         T2: begin
            case (op_class)
               CLS_LDA, CLS_STA, CLS_LDT, CLS_JMP, CLS_JCC: begin
                  o_pc_out   = 1'b1;
                  o_mar_load = 1'b1;
               end
               CLS_ALU: begin
                  o_alu_out     = 1'b1;
                  o_a_load      = 1'b1;
                  o_latch_flags = 1'b1;
               end
               CLS_CMP: begin
                  o_latch_flags = 1'b1;
                  o_alu_op      = ALU_SUB_CODE;
               end
               default: ;
            endcase
         end
         T3: begin
            case (op_class)
               CLS_LDA, CLS_STA: begin
                  o_ram_out  = 1'b1;
                  o_mar_load = 1'b1;
                  o_pc_inc   = 1'b1;
               end
               CLS_LDT: begin
                  o_ram_out = 1'b1;
                  o_t_load  = 1'b1;
                  o_pc_inc  = 1'b1;
               end
               CLS_JMP, CLS_JCC: begin
                  o_ram_out = 1'b1;
                  o_pc_load = jump_taken;
                  o_pc_inc  = ~jump_taken;
               end
               default: ;
            endcase
         end
         T4: begin
            case (op_class)
               CLS_LDA: begin
                  o_ram_out = 1'b1;
                  o_a_load  = 1'b1;
               end
               CLS_STA: begin
                  o_a_out     = 1'b1;
                  o_ram_write = 1'b1;
               end
               default: ;
            endcase
         end
         HALT:    o_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer.
module tb_instruction_sequencer;

   logic       clk;
   logic       rst_n;
   logic       clk_en;
   logic [7:0] instr;
   logic       zero, carry, odd;
   logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load;
   logic       a_load, a_out, t_load, alu_out, latch_flags, halt;
   logic [3:0] alu_op;
   logic [2:0] tstate;
   logic [12:0] strobes;

   int checks;
   int errors;

   localparam logic [12:0] S_PCO  = 13'h1000;
   localparam logic [12:0] S_INC  = 13'h0800;
   localparam logic [12:0] S_PCL  = 13'h0400;
   localparam logic [12:0] S_MAR  = 13'h0200;
   localparam logic [12:0] S_RO   = 13'h0100;
   localparam logic [12:0] S_RW   = 13'h0080;
   localparam logic [12:0] S_IRL  = 13'h0040;
   localparam logic [12:0] S_AL   = 13'h0020;
   localparam logic [12:0] S_AO   = 13'h0010;
   localparam logic [12:0] S_TL   = 13'h0008;
   localparam logic [12:0] S_ALUO = 13'h0004;
   localparam logic [12:0] S_LF   = 13'h0002;
   localparam logic [12:0] S_HLT  = 13'h0001;

   instruction_sequencer #(
      .ALU_OP_WIDTH (4),
      .ALU_SUB_CODE (4'd1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clk_en        (clk_en),
      .i_instruction (instr),
      .i_zero        (zero),
      .i_carry       (carry),
      .i_odd         (odd),
      .o_pc_out      (pc_out),
      .o_pc_inc      (pc_inc),
      .o_pc_load     (pc_load),
      .o_mar_load    (mar_load),
      .o_ram_out     (ram_out),
      .o_ram_write   (ram_write),
      .o_ir_load     (ir_load),
      .o_a_load      (a_load),
      .o_a_out       (a_out),
      .o_t_load      (t_load),
      .o_alu_out     (alu_out),
      .o_latch_flags (latch_flags),
      .o_alu_op      (alu_op),
      .o_halt        (halt),
      .o_tstate      (tstate)
   );

   assign strobes = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load,
                     a_load, a_out, t_load, alu_out, latch_flags, halt};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in T0 with rst_n released, mid-cycle
   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] exp_t [2];
      rst_n  = 1'b0;
      clk_en = 1'b1;
      instr  = 8'h3A;
      zero = 1'b0; carry = 1'b0; odd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (tstate !== 3'd0) begin
            errors++;
            $display("FAIL reset_tstate: got %0d expected 0", tstate);
         end
         checks++;
         if (strobes !== (S_PCO | S_MAR)) begin
            errors++;
            $display("FAIL reset_strobes: got %h expected %h", strobes, S_PCO | S_MAR);
         end
         checks++;
         if (alu_op !== 4'hA) begin
            errors++;
            $display("FAIL reset_alu_op: got %h expected a", alu_op);
         end
      end
      rst_n = 1'b1;
      exp_t[0] = 3'd1;
      exp_t[1] = 3'd2;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (tstate !== exp_t[i]) begin
            errors++;
            $display("FAIL release_tstate: got %0d expected %0d", tstate, exp_t[i]);
         end
      end
   endtask

   task automatic test_load_store();
      logic [12:0] exp_s [6];
      logic [2:0]  exp_t [6];
      for (int k = 0; k < 2; k++) begin
         instr  = (k == 0) ? 8'h10 : 8'h25;
         clk_en = 1'b1;
         exp_s[0] = S_PCO | S_MAR;
         exp_s[1] = S_RO | S_IRL | S_INC;
         exp_s[2] = S_PCO | S_MAR;
         exp_s[3] = S_RO | S_MAR | S_INC;
         exp_s[4] = (k == 0) ? (S_RO | S_AL) : (S_AO | S_RW);
         exp_s[5] = S_PCO | S_MAR;
         exp_t = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
         apply_reset();
         for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            checks++;
            if (tstate !== exp_t[i]) begin
               errors++;
               $display("FAIL ldsta_tstate instr=%h step %0d: got %0d expected %0d",
                        instr, i, tstate, exp_t[i]);
            end
            checks++;
            if (strobes !== exp_s[i]) begin
               errors++;
               $display("FAIL ldsta_strobes instr=%h step %0d: got %h expected %h",
                        instr, i, strobes, exp_s[i]);
            end
         end
      end
   endtask

   task automatic test_ldt();
      instr  = 8'h35;
      clk_en = 1'b1;
      apply_reset();
      step(); step();
      checks++;
      if (strobes !== (S_PCO | S_MAR)) begin
         errors++;
         $display("FAIL ldt_t2: got %h expected %h", strobes, S_PCO | S_MAR);
      end
      step();
      checks++;
      if (strobes !== (S_RO | S_TL | S_INC) || tstate !== 3'd3) begin
         errors++;
         $display("FAIL ldt_t3: got %h/t%0d expected %h/t3", strobes, tstate, S_RO | S_TL | S_INC);
      end
      step();
      checks++;
      if (tstate !== 3'd0) begin
         errors++;
         $display("FAIL ldt_return: got %0d expected 0", tstate);
      end
   endtask

   task automatic test_alu_cmp();
      logic [7:0]  ins   [4];
      logic [12:0] exp_s [4];
      logic [3:0]  exp_op[4];
      ins    = '{8'h42, 8'h57, 8'h4C, 8'h50};
      exp_s  = '{S_ALUO | S_AL | S_LF, S_LF, S_ALUO | S_AL | S_LF, S_LF};
      exp_op = '{4'd2, 4'd1, 4'hC, 4'd1};
      clk_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         instr = ins[k];
         apply_reset();
         step(); step();
         checks++;
         if (strobes !== exp_s[k]) begin
            errors++;
            $display("FAIL alu_cmp_strobes instr=%h: got %h expected %h", instr, strobes, exp_s[k]);
         end
         checks++;
         if (alu_op !== exp_op[k]) begin
            errors++;
            $display("FAIL alu_cmp_op instr=%h: got %h expected %h", instr, alu_op, exp_op[k]);
         end
         step();
         checks++;
         if (tstate !== 3'd0) begin
            errors++;
            $display("FAIL alu_cmp_return instr=%h: got %0d expected 0", instr, tstate);
         end
      end
   endtask

   task automatic test_nop();
      logic [7:0] ins [2];
      ins = '{8'h00, 8'h8C};
      clk_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         instr = ins[k];
         apply_reset();
         step(); step();
         checks++;
         if (strobes !== 13'h0000 || tstate !== 3'd2) begin
            errors++;
            $display("FAIL nop_t2 instr=%h: got %h/t%0d expected 0000/t2", instr, strobes, tstate);
         end
         step();
         checks++;
         if (tstate !== 3'd0) begin
            errors++;
            $display("FAIL nop_return instr=%h: got %0d expected 0", instr, tstate);
         end
      end
   endtask

   task automatic test_jcc();
      logic [7:0]  ins   [11];
      logic [2:0]  flg   [11];
      logic        taken [11];
      logic [12:0] exp_s;
      ins   = '{8'h70, 8'h70, 8'h74, 8'h74, 8'h71, 8'h72, 8'h72, 8'h73, 8'h77, 8'h60, 8'h65};
      flg   = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b000, 3'b000, 3'b000, 3'b010};
      taken = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      clk_en = 1'b1;
      for (int k = 0; k < 11; k++) begin
         instr = ins[k];
         {zero, carry, odd} = flg[k];
         exp_s = taken[k] ? (S_RO | S_PCL) : (S_RO | S_INC);
         apply_reset();
         step(); step(); step();
         checks++;
         if (strobes !== exp_s || tstate !== 3'd3) begin
            errors++;
            $display("FAIL jcc_t3 instr=%h zco=%b: got %h/t%0d expected %h/t3",
                     instr, flg[k], strobes, tstate, exp_s);
         end
         step();
         checks++;
         if (tstate !== 3'd0) begin
            errors++;
            $display("FAIL jcc_return instr=%h: got %0d expected 0", instr, tstate);
         end
      end
      zero = 1'b0; carry = 1'b0; odd = 1'b0;
   endtask

   task automatic test_clk_en();
      instr  = 8'h10;
      clk_en = 1'b0;
      apply_reset();
      step(); step();
      checks++;
      if (tstate !== 3'd0) begin
         errors++;
         $display("FAIL clken_t0_hold: got %0d expected 0", tstate);
      end
      clk_en = 1'b1;
      step(); step(); step();
      clk_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (tstate !== 3'd3 || strobes !== (S_RO | S_MAR | S_INC)) begin
            errors++;
            $display("FAIL clken_freeze cycle %0d: got %h/t%0d expected %h/t3",
                     i, strobes, tstate, S_RO | S_MAR | S_INC);
         end
      end
      clk_en = 1'b1;
      step();
      checks++;
      if (tstate !== 3'd4 || strobes !== (S_RO | S_AL)) begin
         errors++;
         $display("FAIL clken_resume: got %h/t%0d expected %h/t4", strobes, tstate, S_RO | S_AL);
      end
   endtask

   task automatic test_halt();
      instr  = 8'hF0;
      clk_en = 1'b1;
      apply_reset();
      step(); step();
      checks++;
      if (strobes !== 13'h0000 || tstate !== 3'd2) begin
         errors++;
         $display("FAIL hlt_t2: got %h/t%0d expected 0000/t2", strobes, tstate);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (tstate !== 3'd7 || strobes !== S_HLT) begin
            errors++;
            $display("FAIL halt_hold cycle %0d: got %h/t%0d expected %h/t7", i, strobes, tstate, S_HLT);
         end
      end
      // asynchronous exit from HALT, checked before any clock edge
      rst_n = 1'b0;
      #1;
      checks++;
      if (tstate !== 3'd0 || strobes !== (S_PCO | S_MAR)) begin
         errors++;
         $display("FAIL halt_async_reset: got %h/t%0d expected %h/t0", strobes, tstate, S_PCO | S_MAR);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (tstate !== 3'd1) begin
         errors++;
         $display("FAIL halt_reset_release: got %0d expected 1", tstate);
      end
   endtask

   task automatic test_mid_reset();
      instr  = 8'h60;
      clk_en = 1'b1;
      apply_reset();
      step(); step(); step();
      checks++;
      if (tstate !== 3'd3) begin
         errors++;
         $display("FAIL jmp_reach_t3: got %0d expected 3", tstate);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tstate !== 3'd0 || strobes !== (S_PCO | S_MAR) || alu_op !== 4'h0) begin
         errors++;
         $display("FAIL jmp_async_reset: got %h/t%0d/op%h expected %h/t0/op0",
                  strobes, tstate, alu_op, S_PCO | S_MAR);
      end
      step(); step();
      checks++;
      if (tstate !== 3'd0) begin
         errors++;
         $display("FAIL jmp_reset_held: got %0d expected 0", tstate);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (tstate !== 3'd1) begin
         errors++;
         $display("FAIL jmp_reset_release: got %0d expected 1", tstate);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clk_en = 1'b0;
      instr  = 8'h00;
      zero = 1'b0; carry = 1'b0; odd = 1'b0;
      test_reset();
      test_load_store();
      test_ldt();
      test_alu_cmp();
      test_nop();
      test_jcc();
      test_clk_en();
      test_halt();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
